// File: rtl/vslc_spi_pkg.sv
// Shared definitions for the emulated 25xx serial EEPROM: opcodes, status bits, FSM states.
package vslc_spi_pkg;

  localparam logic [7:0] EEPROM_READ_COMMAND  = 8'h03;
  localparam logic [7:0] EEPROM_WRITE_COMMAND = 8'h02;
  localparam logic [7:0] EEPROM_WREN_COMMAND  = 8'h06;
  localparam logic [7:0] EEPROM_WRDI_COMMAND  = 8'h04;
  localparam logic [7:0] EEPROM_RDSR_COMMAND  = 8'h05;

  localparam int STATUS_WIP_BIT = 0;
  localparam int STATUS_WEL_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_STAT,
    ST_WAIT,
    ST_IGNORE
  } spi_state_e;

  // Writes never run in the background, so WIP always reads as zero.
  function automatic logic [7:0] status_byte(input logic wel);
    logic [7:0] s;
    s                 = 8'h00;
    s[STATUS_WEL_BIT] = wel;
    s[STATUS_WIP_BIT] = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous SPI wire plus single-cycle rise/fall pulses.
// Level is valid 2 clk after the input changes; the pulses coincide with the level change.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_eeprom_target.sv
// SPI mode-0 target emulating a 25xx EEPROM (READ/WRITE/WREN/WRDI/RDSR) from an internal byte array.
// SPI edges act 3 clk after they occur; the host load port is accepted only while the bus is idle.
module spi_eeprom_target
  import vslc_spi_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_copi,
  output logic              spi_cipo,
  output logic              spi_cipo_oe,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              load_ready
);

  function automatic logic [ADDR_W-1:0] mod_depth(input logic [ADDR_W-1:0] a);
    logic [31:0] wide;
    wide = 32'(a) % 32'(DEPTH);
    return ADDR_W'(wide);
  endfunction

  logic sck_lvl_unused, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (spi_sck),
    .level    (sck_lvl_unused),
    .rise     (sck_rise),
    .fall     (sck_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (spi_cs_n),
    .level    (cs_lvl),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  logic [7:0] mem [DEPTH];

  spi_state_e        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        op_q, op_d;
  logic              wel_q, wel_d;
  logic              extra_q, extra_d;
  logic              commit_q, commit_d;
  logic              cipo_q, cipo_d;
  logic              oe_q, oe_d;
  logic              load_ready_q, load_ready_d;
  logic              copi_meta_q, copi_meta_d;
  logic              copi_sync_q, copi_sync_d;

  logic [7:0]        rx_byte;
  logic              byte_done;
  logic [ADDR_W-1:0] next_addr, rx_addr, load_idx;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;

  // copi goes through the same depth as sck so it lines up with the rise pulse.
  assign rx_byte   = {shift_q[6:0], copi_sync_q};
  assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
  assign next_addr = mod_depth(addr_q + ADDR_W'(1));
  assign rx_addr   = mod_depth(ADDR_W'(rx_byte));
  assign load_idx  = mod_depth(load_addr);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    op_d        = op_q;
    wel_d       = wel_q;
    extra_d     = extra_q;
    commit_d    = commit_q;
    cipo_d      = cipo_q;
    oe_d        = oe_q;
    copi_meta_d = spi_copi;
    copi_sync_d = copi_meta_q;
    mem_we      = 1'b0;
    mem_waddr   = load_idx;
    mem_wdata   = load_data;

    if (cs_rise) begin
      state_d   = ST_IDLE;
      oe_d      = 1'b0;
      cipo_d    = 1'b0;
      bit_cnt_d = 3'd0;
      // WREN/WRDI count only when exactly one full byte was clocked.
      if (state_q == ST_WAIT && !extra_q) begin
        if (op_q == EEPROM_WREN_COMMAND)      wel_d = 1'b1;
        else if (op_q == EEPROM_WRDI_COMMAND) wel_d = 1'b0;
      end
      if (op_q == EEPROM_WRITE_COMMAND && commit_q) wel_d = 1'b0;
    end else if (cs_fall && state_q == ST_IDLE) begin
      state_d   = ST_CMD;
      bit_cnt_d = 3'd0;
      op_d      = 8'h00;
      extra_d   = 1'b0;
      commit_d  = 1'b0;
    end else if (!cs_lvl && state_q != ST_IDLE) begin
      if (sck_rise) begin
        shift_d   = rx_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
        case (state_q)
          ST_CMD: begin
            if (byte_done) begin
              op_d = rx_byte;
              case (rx_byte)
                EEPROM_READ_COMMAND, EEPROM_WRITE_COMMAND: state_d = ST_ADDR;
                EEPROM_WREN_COMMAND, EEPROM_WRDI_COMMAND:  state_d = ST_WAIT;
                EEPROM_RDSR_COMMAND: begin
                  state_d = ST_STAT;
                  tx_d    = status_byte(wel_q);
                end
                default: state_d = ST_IGNORE;
              endcase
            end
          end
          ST_ADDR: begin
            if (byte_done) begin
              addr_d = rx_addr;
              if (op_q == EEPROM_READ_COMMAND) begin
                state_d = ST_RD_DATA;
                tx_d    = mem[rx_addr];
              end else begin
                state_d = ST_WR_DATA;
              end
            end
          end
          ST_RD_DATA: begin
            if (byte_done) begin
              addr_d = next_addr;
              tx_d   = mem[next_addr];
            end
          end
          ST_WR_DATA: begin
            if (byte_done) begin
              if (wel_q) begin
                mem_we    = 1'b1;
                mem_waddr = addr_q;
                mem_wdata = rx_byte;
                commit_d  = 1'b1;
              end
              addr_d = next_addr;
            end
          end
          ST_STAT: begin
            if (byte_done) tx_d = status_byte(wel_q);
          end
          ST_WAIT: extra_d = 1'b1;
          default: ;
        endcase
      end else if (sck_fall && (state_q == ST_RD_DATA || state_q == ST_STAT)) begin
        cipo_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
        oe_d   = 1'b1;
      end
    end

    // load_ready_q already implies IDLE, so this never collides with an SPI write.
    if (!mem_we && load_we && load_ready_q) begin
      mem_we    = 1'b1;
      mem_waddr = load_idx;
      mem_wdata = load_data;
    end

    load_ready_d = cs_lvl && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      tx_q         <= 8'h00;
      addr_q       <= '0;
      op_q         <= 8'h00;
      wel_q        <= 1'b0;
      extra_q      <= 1'b0;
      commit_q     <= 1'b0;
      cipo_q       <= 1'b0;
      oe_q         <= 1'b0;
      load_ready_q <= 1'b0;
      copi_meta_q  <= 1'b0;
      copi_sync_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      addr_q       <= addr_d;
      op_q         <= op_d;
      wel_q        <= wel_d;
      extra_q      <= extra_d;
      commit_q     <= commit_d;
      cipo_q       <= cipo_d;
      oe_q         <= oe_d;
      load_ready_q <= load_ready_d;
      copi_meta_q  <= copi_meta_d;
      copi_sync_q  <= copi_sync_d;
    end
  end

  // Storage survives reset so preloaded images outlive a sequencer restart.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign spi_cipo    = cipo_q;
  assign spi_cipo_oe = oe_q;
  assign load_ready  = load_ready_q;

endmodule

// File: tb/tb_spi_eeprom_target.sv
// Randomised bench for spi_eeprom_target against a transaction-level EEPROM model.
module tb_spi_eeprom_target;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_sck, spi_cs_n, spi_copi;
  logic       spi_cipo, spi_cipo_oe;
  logic       load_we;
  logic [7:0] load_addr, load_data;
  logic       load_ready;

  spi_eeprom_target #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_copi    (spi_copi),
    .spi_cipo    (spi_cipo),
    .spi_cipo_oe (spi_cipo_oe),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_ready  (load_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] mmem [256];
  logic       mwel;
  logic [7:0] tx_buf [16];
  logic [7:0] rx_buf [16];
  logic [7:0] oe_buf [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx, output logic [7:0] oe);
    rx = 8'h00;
    oe = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_copi = tx[7-i];
      repeat (HALF) @(negedge clk);
      rx[7-i] = spi_cipo;
      oe[7-i] = spi_cipo_oe;
      spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic run_txn(input int nb, input int tail);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int b = 0; b < nb; b++) spi_bits(tx_buf[b], 8, rx_buf[b], oe_buf[b]);
    if (tail > 0) spi_bits(tx_buf[nb], tail, rx_buf[nb], oe_buf[nb]);
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    spi_copi = 1'b0;
    repeat (2*HALF) @(negedge clk);
  endtask

  task automatic host_load(input logic [7:0] a, input logic [7:0] d);
    int t;
    t = 0;
    while (load_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("load_ready", 32'(load_ready), 32'd1);
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_we = 1'b0;
    mmem[a] = d;
  endtask

  task automatic do_read(input logic [7:0] a, input int n, input string tag);
    logic [7:0] ai;
    tx_buf[0] = 8'h03;
    tx_buf[1] = a;
    for (int i = 0; i < n; i++) tx_buf[2+i] = 8'($urandom);
    run_txn(2 + n, 0);
    check({tag, "_hdr_oe"}, 32'({oe_buf[0], oe_buf[1]}), 32'h0);
    for (int i = 0; i < n; i++) begin
      ai = a + 8'(i);
      check({tag, "_dat"}, 32'(rx_buf[2+i]), 32'(mmem[ai]));
      check({tag, "_oe"}, 32'(oe_buf[2+i]), 32'hFF);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input int n, input int tail, input logic [7:0] d0, input string tag);
    logic [7:0] acc;
    tx_buf[0] = 8'h02;
    tx_buf[1] = a;
    for (int i = 0; i <= n; i++) tx_buf[2+i] = d0 + 8'(i * 37);
    run_txn(2 + n, tail);
    acc = 8'h00;
    for (int i = 0; i < 2 + n; i++) acc |= oe_buf[i];
    if (tail > 0) acc |= oe_buf[2+n];
    check({tag, "_oe"}, 32'(acc), 32'h0);
    if (mwel && n > 0) begin
      for (int i = 0; i < n; i++) mmem[a + 8'(i)] = tx_buf[2+i];
      mwel = 1'b0;
    end
  endtask

  task automatic do_cmd(input logic [7:0] op, input int extra, input string tag);
    tx_buf[0] = op;
    tx_buf[1] = 8'($urandom);
    run_txn(1, extra);
    check({tag, "_oe"}, 32'(oe_buf[0] | (extra > 0 ? oe_buf[1] : 8'h00)), 32'h0);
    if (extra == 0) begin
      if (op == 8'h06) mwel = 1'b1;
      if (op == 8'h04) mwel = 1'b0;
    end
  endtask

  task automatic do_rdsr(input int n, input string tag);
    tx_buf[0] = 8'h05;
    for (int i = 0; i < n; i++) tx_buf[1+i] = 8'($urandom);
    run_txn(1 + n, 0);
    check({tag, "_hdr_oe"}, 32'(oe_buf[0]), 32'h0);
    for (int i = 0; i < n; i++) begin
      check({tag, "_sr"}, 32'(rx_buf[1+i]), 32'({6'b0, mwel, 1'b0}));
      check({tag, "_oe"}, 32'(oe_buf[1+i]), 32'hFF);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] tmp, rx8, oe8, d;
    int kind, n;

    rst = 1'b1; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_copi = 1'b0;
    load_we = 1'b0; load_addr = 8'h00; load_data = 8'h00;
    mwel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_oe", 32'(spi_cipo_oe), 32'd0);
    check("rst_cipo", 32'(spi_cipo), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 256; i++) host_load(8'(i), 8'($urandom));

    // 1: basic three-byte read
    host_load(8'h10, 8'hA5); host_load(8'h11, 8'h3C); host_load(8'h12, 8'hFF);
    do_read(8'h10, 3, "t1");
    check("t1_lit0", 32'(rx_buf[2]), 32'hA5);
    check("t1_lit1", 32'(rx_buf[3]), 32'h3C);
    check("t1_lit2", 32'(rx_buf[4]), 32'hFF);

    // 2: address wrap
    host_load(8'hFF, 8'h11); host_load(8'h00, 8'h22);
    do_read(8'hFF, 2, "t2");
    check("t2_wrap", 32'(rx_buf[3]), 32'h22);

    // 3: write enable handling
    host_load(8'h20, 8'h00);
    do_write(8'h20, 1, 0, 8'h55, "t3_nowel");
    do_read(8'h20, 1, "t3_rd0");
    check("t3_unchanged", 32'(rx_buf[2]), 32'h00);
    do_rdsr(1, "t3_sr0");
    do_cmd(8'h06, 0, "t3_wren");
    do_rdsr(1, "t3_sr1");
    check("t3_sr_wel", 32'(rx_buf[1]), 32'h02);
    do_write(8'h20, 1, 0, 8'h55, "t3_wr");
    do_read(8'h20, 1, "t3_rd1");
    check("t3_written", 32'(rx_buf[2]), 32'h55);
    do_rdsr(1, "t3_sr2");
    check("t3_sr_clr", 32'(rx_buf[1]), 32'h00);

    // 4: partial data byte is dropped and WEL survives
    tmp = 8'($urandom);
    host_load(8'h30, tmp);
    do_cmd(8'h06, 0, "t4_wren");
    do_write(8'h30, 0, 4, ~tmp, "t4_partial");
    do_rdsr(1, "t4_sr");
    check("t4_sr_lit", 32'(rx_buf[1]), 32'h02);
    do_read(8'h30, 1, "t4_rd");
    check("t4_keep", 32'(rx_buf[2]), 32'(tmp));

    // 5: unknown opcode, load_ready tracking
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(8'hAB, 8, rx8, oe8);
    check("t5_ready_low", 32'(load_ready), 32'd0);
    d = oe8;
    spi_bits(8'($urandom), 8, rx8, oe8); d |= oe8;
    spi_bits(8'($urandom), 8, rx8, oe8); d |= oe8;
    check("t5_oe", 32'(d | 8'(spi_cipo_oe)), 32'h0);
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_ready_back", 32'(load_ready), 32'd1);
    repeat (2*HALF) @(negedge clk);
    do_read(8'h10, 1, "t5_rd");

    // 6: reset in the middle of a read
    tmp = 8'($urandom);
    host_load(8'h40, tmp);
    do_cmd(8'h06, 0, "t6_wren");
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(8'h03, 8, rx8, oe8);
    spi_bits(8'h40, 8, rx8, oe8);
    spi_bits(8'h00, 5, rx8, oe8);
    check("t6_oe_before", 32'(spi_cipo_oe), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_oe_rst", 32'(spi_cipo_oe), 32'd0);
    check("t6_cipo_rst", 32'(spi_cipo), 32'd0);
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    mwel = 1'b0;
    repeat (4) @(negedge clk);
    do_rdsr(1, "t6_sr");
    check("t6_sr_lit", 32'(rx_buf[1]), 32'h00);
    do_read(8'h40, 1, "t6_rd");
    check("t6_keep", 32'(rx_buf[2]), 32'(tmp));

    // random traffic
    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0, 5: do_read(8'($urandom), $urandom_range(1, 3), "r_read");
        1: do_write(8'($urandom), $urandom_range(0, 2), $urandom_range(0, 7), 8'($urandom), "r_write");
        2: begin
          n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
          do_cmd(8'h06, n, "r_wren");
        end
        3: begin
          n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
          do_cmd(8'h04, n, "r_wrdi");
        end
        default: do_rdsr($urandom_range(1, 2), "r_rdsr");
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
